hub75_scan_ctrl: RTL and testbench

- Display scan sequencer for the HUB75 panel.
- Reads RGB565 pixels from the frame buffer read port, one upper and one lower pixel per column.
- Slices each pixel into 6 Binary Coded Modulation (BCM) bit planes, shifts them out to the panel, latches, and enables output for the programmed BCM on-time per plane.
- Sits between the APB control/status register block (control, pixels_per_row, BCM counts) and the panel pins; it is the only reader of the frame buffer.

---
 rtl/hub75_scan_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 panel scan sequencer.
// Reads an upper and a lower RGB565 pixel per column from the frame buffer,
// slices them into BCM bit planes, shifts each plane out, latches it and holds
// output enable for that plane's programmed on-time.
// Optional build macro: HUB75_TEST_PATTERN_EN. When it is defined and test_mode
// is high, an internal column pattern replaces the frame buffer data.
//
// Panel handshake: colour bits are valid for the whole of ph2 and ph3 of a
// column, and hub_clk rises at the start of ph3. hub_lat pulses for one cycle
// once the row is shifted. hub_oe_n is low only while in DISPLAY.
module hub75_scan_ctrl #(
    parameter int ROW_PAIRS  = 32,
    parameter int BCM_PLANES = 6,
    parameter int MEM_AW     = 15,
    parameter int MAX_PPR    = 512
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     enable,
    input  logic [9:0]               pixels_per_row,
    input  logic [BCM_PLANES*14-1:0] bcm_count,
    input  logic                     test_mode,
    output logic                     mem_rd,
    output logic [MEM_AW-1:0]        mem_raddr,
    input  logic [15:0]              mem_rdata,
    output logic                     hub_r1,
    output logic                     hub_g1,
    output logic                     hub_b1,
    output logic                     hub_r2,
    output logic                     hub_g2,
    output logic                     hub_b2,
    output logic                     hub_clk,
    output logic                     hub_lat,
    output logic                     hub_oe_n,
    output logic [4:0]               hub_addr,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int ROW_AW = MEM_AW - 9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_LATCH   = 3'd3,
        S_DISPLAY = 3'd4,
        S_ADVANCE = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [4:0]  row;
    logic [2:0]  plane;
    logic [9:0]  ppr_q;
    logic [13:0] bcm_q;
    logic [9:0]  col;
    logic [1:0]  phase;
    logic        lat_second;
    logic [13:0] dcnt;
    logic [15:0] upper_q;
    logic [5:0]  colour_q;

    logic [9:0]  ppr_clamped;
    logic        last_col;
    logic        last_plane;
    logic        last_row;
    logic [15:0] upper_src;
    logic [15:0] lower_src;
    logic        read_en;
    logic [5:0]  colour_live;
    logic [ROW_AW-1:0] row_up;
    logic [ROW_AW-1:0] row_lo;

    // Returns {r, g, b} for one pixel in bit plane p.
    function automatic logic [2:0] slice_rgb(input logic [15:0] px, input logic [2:0] p);
        logic [3:0] gi;
        logic [3:0] ri;
        logic [3:0] bi;
        logic [2:0] res;
        gi = 4'(p) + 4'd5;
        ri = 4'(p) + 4'd10;
        bi = 4'(p) - 4'd1;
        res = 3'b000;
        res[1] = px[gi];
        if (p != 3'd0) begin
            res[2] = px[ri];
            res[0] = px[bi];
        end
        return res;
    endfunction

    assign ppr_clamped = (pixels_per_row > 10'(MAX_PPR)) ? 10'(MAX_PPR) : pixels_per_row;
    assign last_col    = (col == ppr_q - 10'd1);
    assign last_plane  = (plane == 3'(BCM_PLANES - 1));
    assign last_row    = (row == 5'(ROW_PAIRS - 1));
    assign row_up      = ROW_AW'(row);
    assign row_lo      = ROW_AW'(row) + ROW_AW'(ROW_PAIRS);

`ifdef HUB75_TEST_PATTERN_EN
    logic        pattern_q;
    logic [15:0] pattern_px;

    assign pattern_px = {col[4:0], col[5:0], col[4:0]};
    assign upper_src  = pattern_q ? pattern_px : upper_q;
    assign lower_src  = pattern_q ? ~pattern_px : mem_rdata;
    assign read_en    = ~pattern_q;

    // Test-mode select is shadowed at LOAD like the other settings.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pattern_q <= 1'b0;
        end else if (state == S_LOAD) begin
            pattern_q <= test_mode;
        end
    end
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign upper_src        = upper_q;
    assign lower_src        = mem_rdata;
    assign read_en          = 1'b1;
`endif

    assign colour_live = {slice_rgb(upper_src, plane), slice_rgb(lower_src, plane)};

    // State register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (enable) state_next = S_LOAD;
            S_LOAD:    state_next = (ppr_clamped == 10'd0) ? S_LATCH : S_SHIFT;
            S_SHIFT:   if (phase == 2'd3 && last_col) state_next = S_LATCH;
            S_LATCH:   if (lat_second) state_next = (bcm_q == 14'd0) ? S_ADVANCE : S_DISPLAY;
            S_DISPLAY: if (dcnt == 14'd0) state_next = S_ADVANCE;
            S_ADVANCE: state_next = enable ? S_LOAD : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath: shadow registers, column/phase counters, pixel capture, row/plane stepping.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            row        <= 5'd0;
            plane      <= 3'd0;
            ppr_q      <= 10'd0;
            bcm_q      <= 14'd0;
            col        <= 10'd0;
            phase      <= 2'd0;
            lat_second <= 1'b0;
            dcnt       <= 14'd0;
            upper_q    <= 16'd0;
            colour_q   <= 6'd0;
            hub_clk    <= 1'b0;
            hub_addr   <= 5'd0;
        end else begin
            // Shift clock is high exactly during ph3.
            hub_clk <= (state == S_SHIFT) && (phase == 2'd2);
            case (state)
                S_LOAD: begin
                    ppr_q      <= ppr_clamped;
                    bcm_q      <= bcm_count[14*plane +: 14];
                    col        <= 10'd0;
                    phase      <= 2'd0;
                    lat_second <= 1'b0;
                end
                S_SHIFT: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd1) upper_q <= mem_rdata;
                    if (phase == 2'd2) colour_q <= colour_live;
                    if (phase == 2'd3) col <= col + 10'd1;
                end
                S_LATCH: begin
                    lat_second <= 1'b1;
                    if (!lat_second) hub_addr <= row;
                    dcnt <= bcm_q - 14'd1;
                end
                S_DISPLAY: begin
                    dcnt <= dcnt - 14'd1;
                end
                S_ADVANCE: begin
                    if (last_plane) begin
                        plane <= 3'd0;
                        row   <= last_row ? 5'd0 : row + 5'd1;
                    end else begin
                        plane <= plane + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem_rd     = 1'b0;
        mem_raddr  = '0;
        hub_lat    = 1'b0;
        hub_oe_n   = 1'b1;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);
        {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = colour_q;
        case (state)
            S_SHIFT: begin
                if (phase == 2'd0) begin
                    mem_rd    = read_en;
                    mem_raddr = {row_up, col[8:0]};
                end else if (phase == 2'd1) begin
                    mem_rd    = read_en;
                    mem_raddr = {row_lo, col[8:0]};
                end else if (phase == 2'd2) begin
                    {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = colour_live;
                end
            end
            S_LATCH:   hub_lat = ~lat_second;
            S_DISPLAY: hub_oe_n = 1'b0;
            S_ADVANCE: frame_done = last_plane && last_row;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Testbench for hub75_scan_ctrl: directed steps, frame buffer model,
// colour-bit scoreboard and a passive monitor of the panel pins.
module tb_hub75_scan_ctrl;

    logic        pclk;
    logic        preset;
    logic        enable;
    logic [9:0]  pixels_per_row;
    logic [83:0] bcm_count;
    logic        test_mode;
    logic        mem_rd;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
    logic        hub_clk, hub_lat, hub_oe_n;
    logic [4:0]  hub_addr;
    logic        frame_done;
    logic        busy;

    hub75_scan_ctrl dut (
        .pclk(pclk), .preset(preset), .enable(enable),
        .pixels_per_row(pixels_per_row), .bcm_count(bcm_count),
        .test_mode(test_mode), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
        .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
        .hub_addr(hub_addr), .frame_done(frame_done), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    logic fill_ones = 1'b0;
    logic sb_on = 1'b0;

    logic [5:0] exp_q[$];
    logic [5:0] obs_q[$];
    logic [4:0] addr_log[$];

    // monitor counters
    int cyc = 0, clk_rises = 0, lat_pulses = 0, lat_high = 0, oe_low = 0;
    int oe_run = 0, last_run = 0, fd_pulses = 0, fd_high = 0, rd_count = 0;
    int max_col = 0, last_clk_cyc = 0, lat_cyc = 0, first_oe_cyc = 0;
    logic prev_clk = 1'b0, prev_lat = 1'b0, prev_oe_n = 1'b1, prev_fd = 1'b0;

    // clock / reset block
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic logic [15:0] pix(input logic [14:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'd4321;
        return t[15:0] ^ t[31:16];
    endfunction

    // Expected {r1,g1,b1,r2,g2,b2} for an upper/lower pixel pair in plane p.
    function automatic logic [5:0] exp_bits(input logic [15:0] up, input logic [15:0] lo, input int p);
        logic [2:0] u;
        logic [2:0] l;
        u = 3'b000;
        l = 3'b000;
        u[1] = up[5 + p];
        l[1] = lo[5 + p];
        if (p > 0) begin
            u[2] = up[11 + p - 1];
            l[2] = lo[11 + p - 1];
            u[0] = up[p - 1];
            l[0] = lo[p - 1];
        end
        return {u, l};
    endfunction

    // frame buffer model: data valid the cycle after mem_rd
    always @(posedge pclk) begin
        if (mem_rd) mem_rdata <= fill_ones ? 16'hFFFF : pix(mem_raddr);
    end

    // passive pin monitor, sampled on the falling edge
    always @(negedge pclk) begin
        cyc = cyc + 1;
        if (hub_clk && !prev_clk) begin
            clk_rises = clk_rises + 1;
            last_clk_cyc = cyc;
            if (sb_on) obs_q.push_back({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2});
        end
        if (hub_lat) lat_high = lat_high + 1;
        if (hub_lat && !prev_lat) begin
            lat_pulses = lat_pulses + 1;
            lat_cyc = cyc;
        end
        if (prev_lat && !hub_lat) addr_log.push_back(hub_addr);
        if (!hub_oe_n) begin
            oe_low = oe_low + 1;
            oe_run = oe_run + 1;
            if (prev_oe_n) first_oe_cyc = cyc;
        end else if (!prev_oe_n) begin
            last_run = oe_run;
            oe_run = 0;
        end
        if (frame_done) fd_high = fd_high + 1;
        if (frame_done && !prev_fd) fd_pulses = fd_pulses + 1;
        if (mem_rd) begin
            rd_count = rd_count + 1;
            if (int'(mem_raddr[8:0]) > max_col) max_col = int'(mem_raddr[8:0]);
        end
        prev_clk = hub_clk;
        prev_lat = hub_lat;
        prev_oe_n = hub_oe_n;
        prev_fd = frame_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            #1;
        end
    endtask

    task automatic do_reset();
        preset = 1'b1;
        step(2);
        preset = 1'b0;
        step(1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            step(1);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_rises(input string tag, input int target, input int bound);
        int n;
        n = 0;
        while (clk_rises < target && n < bound) begin
            step(1);
            n++;
        end
        check({tag, "_rise_wait"}, 32'(clk_rises >= target), 32'd1);
    endtask

    task automatic check_scoreboard(input string tag);
        logic [5:0] e;
        logic [5:0] o;
        check({tag, "_sb_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_sb_bits"}, 32'(o), 32'(e));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    int b_rise, b_lat, b_lath, b_oe, b_fd, b_fdh, b_rd, b_log, n;

    task automatic snap();
        b_rise = clk_rises; b_lat = lat_pulses; b_lath = lat_high; b_oe = oe_low;
        b_fd = fd_pulses; b_fdh = fd_high; b_rd = rd_count; b_log = addr_log.size();
    endtask

    initial begin
        preset = 1'b1;
        enable = 1'b0;
        test_mode = 1'b0;
        pixels_per_row = 10'd0;
        bcm_count = '0;
        step(3);
        // reset state
        check("rst_oe_n", 32'(hub_oe_n), 32'd1);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);
        check("rst_clk_lat", 32'({hub_clk, hub_lat}), 32'd0);
        check("rst_addr", 32'(hub_addr), 32'd0);
        check("rst_fd_busy", 32'({frame_done, busy}), 32'd0);
        check("rst_colour", 32'({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2}), 32'd0);
        preset = 1'b0;
        step(2);

        // 1: ppr=64, plane 0 on-time 70, frame buffer data from model
        pixels_per_row = 10'd64;
        bcm_count = {6{14'd3}};
        bcm_count[13:0] = 14'd70;
        snap();
        for (int c = 0; c < 64; c++)
            exp_q.push_back(exp_bits(pix({6'd0, 9'(c)}), pix({6'd32, 9'(c)}), 0));
        sb_on = 1'b1;
        enable = 1'b1;
        step(3);
        enable = 1'b0;
        wait_idle("t1", 600);
        sb_on = 1'b0;
        check_scoreboard("t1");
        check("t1_rises", 32'(clk_rises - b_rise), 32'd64);
        check("t1_lat_pulses", 32'(lat_pulses - b_lat), 32'd1);
        check("t1_lat_width", 32'(lat_high - b_lath), 32'd1);
        check("t1_oe_run", 32'(last_run), 32'd70);
        check("t1_oe_total", 32'(oe_low - b_oe), 32'd70);
        check("t1_lat_after_shift", 32'(lat_cyc - last_clk_cyc), 32'd1);
        check("t1_oe_after_lat", 32'(first_oe_cyc - lat_cyc), 32'd2);
        check("t1_oe_n_end", 32'(hub_oe_n), 32'd1);

        // 2: all-ones data, planes 0..3, enable dropped during plane 3 shift
        do_reset();
        fill_ones = 1'b1;
        pixels_per_row = 10'd4;
        bcm_count = {6{14'd1}};
        snap();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back(exp_bits(16'hFFFF, 16'hFFFF, p));
        sb_on = 1'b1;
        enable = 1'b1;
        wait_rises("t2", b_rise + 13, 300);
        enable = 1'b0;
        wait_idle("t2", 200);
        sb_on = 1'b0;
        check_scoreboard("t2");
        check("t2_rises", 32'(clk_rises - b_rise), 32'd16);
        check("t2_oe_total", 32'(oe_low - b_oe), 32'd4);
        check("t2_oe_n_idle", 32'(hub_oe_n), 32'd1);
        fill_ones = 1'b0;

        // 3: full frame, ppr=2, all on-times 1
        do_reset();
        pixels_per_row = 10'd2;
        bcm_count = {6{14'd1}};
        snap();
        enable = 1'b1;
        n = 0;
        while (fd_pulses == b_fd && n < 4000) begin
            step(1);
            n++;
        end
        check("t3_frame_seen", 32'(fd_pulses - b_fd), 32'd1);
        check("t3_lat_at_frame", 32'(lat_pulses - b_lat), 32'd192);
        step(1);
        enable = 1'b0;
        wait_idle("t3", 100);
        check("t3_fd_pulses", 32'(fd_pulses - b_fd), 32'd1);
        check("t3_fd_width", 32'(fd_high - b_fdh), 32'd1);
        check("t3_log_size", 32'(addr_log.size() - b_log), 32'd193);
        if (addr_log.size() >= b_log + 193) begin
            for (int k = 0; k < 192; k++)
                check("t3_hub_addr", 32'(addr_log[b_log + k]), 32'(k / 6));
            check("t3_hub_addr_wrap", 32'(addr_log[b_log + 192]), 32'd0);
        end

        // 4: ppr above the clamp
        do_reset();
        pixels_per_row = 10'd600;
        bcm_count = {6{14'd2}};
        snap();
        enable = 1'b1;
        step(3);
        enable = 1'b0;
        wait_idle("t4", 3000);
        check("t4_rises", 32'(clk_rises - b_rise), 32'd512);
        check("t4_max_col", 32'(max_col), 32'd511);
        check("t4_lat", 32'(lat_pulses - b_lat), 32'd1);

        // 5: ppr=0 skips shifting but still latches and displays
        do_reset();
        pixels_per_row = 10'd0;
        bcm_count = {6{14'd2}};
        bcm_count[13:0] = 14'd5;
        snap();
        enable = 1'b1;
        step(3);
        enable = 1'b0;
        wait_idle("t5", 100);
        check("t5_rises", 32'(clk_rises - b_rise), 32'd0);
        check("t5_lat", 32'(lat_pulses - b_lat), 32'd1);
        check("t5_oe_total", 32'(oe_low - b_oe), 32'd5);
        check("t5_oe_run", 32'(last_run), 32'd5);
        check("t5_no_reads", 32'(rd_count - b_rd), 32'd0);

        // 6: reset asserted mid-DISPLAY releases the panel at once
        do_reset();
        pixels_per_row = 10'd1;
        bcm_count = {6{14'd100}};
        enable = 1'b1;
        n = 0;
        while (hub_oe_n !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        check("t6_display_seen", 32'(hub_oe_n), 32'd0);
        step(10);
        #2;
        preset = 1'b1;
        #1;
        check("t6_async_oe_n", 32'(hub_oe_n), 32'd1);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_lat", 32'(hub_lat), 32'd0);
        step(1);
        preset = 1'b0;
        enable = 1'b0;
        step(2);
        check("t6_idle", 32'(busy), 32'd0);

`ifdef HUB75_TEST_PATTERN_EN
        // 7: internal pattern, planes 0..2, no frame buffer reads
        do_reset();
        test_mode = 1'b1;
        pixels_per_row = 10'd6;
        bcm_count = {6{14'd1}};
        snap();
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 6; c++) begin
                logic [5:0] cv;
                logic [15:0] up;
                cv = 6'(c);
                up = {cv[4:0], cv, cv[4:0]};
                exp_q.push_back(exp_bits(up, ~up, p));
            end
        sb_on = 1'b1;
        enable = 1'b1;
        wait_rises("t7", b_rise + 13, 300);
        enable = 1'b0;
        wait_idle("t7", 200);
        sb_on = 1'b0;
        check_scoreboard("t7");
        check("t7_no_reads", 32'(rd_count - b_rd), 32'd0);
        test_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
